// File: rtl/sync_ram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_stream_reader_pkg
// Purpose  : Shared definitions for the burst stream reader: FSM state
//            encodings and the output buffer depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sync_ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Two entries are enough to absorb the one-cycle RAM read latency while
   // sustaining one beat per clock under continuous ready.
   localparam int unsigned BUF_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/sync_ram_sdp.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_sdp
// Purpose  : Simple-dual-port block RAM, one write port and one registered
//            read port on a single clock. Read-before-write on collision.
// Ports    : clk          - clock, rising edge
//            write_enable - write strobe
//            address_in_w - write address
//            data_in      - write data
//            address_in_r - read address, sampled every edge
//            data_out     - read data register (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_ram_sdp #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     write_enable,
   input  logic [ADDRESS_WIDTH-1:0] address_in_w,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic [ADDRESS_WIDTH-1:0] address_in_r,
   output logic [DATA_WIDTH-1:0]    data_out
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDRESS_WIDTH)-1];

   // No reset on the array or the read register so the tools map this onto
   // a block RAM. Non-blocking semantics give old data on a same-address
   // read/write collision.
   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem[address_in_w] <= data_in;
      end
      data_out <= mem[address_in_r];
   end

endmodule
`default_nettype wire

// File: rtl/sync_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_stream_reader
// Purpose  : Burst read engine over an inferred block RAM. Streams a
//            contiguous (wrapping) address range out on a valid/ready port,
//            hiding the RAM read latency behind a 2-entry flop FIFO.
// Ports    : clk, rst_n                  - clock / async active-low reset
//            write_enable, address_in_w,
//            data_in                     - external memory write port
//            start, start_address, length- burst request (taken when idle)
//            busy, done                  - burst status, done is one pulse
//            data_out, data_valid,
//            data_ready                  - output stream handshake
// Revision : 1.0 - initial release
// ============================================================================
module sync_ram_stream_reader
   import sync_ram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     write_enable,
   input  logic [ADDRESS_WIDTH-1:0] address_in_w,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] start_address,
   input  logic [ADDRESS_WIDTH:0]   length,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     data_valid,
   input  logic                     data_ready
);

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
   logic                     inflight_q, inflight_d;
   logic [1:0]               count_q, count_d;
   logic [DATA_WIDTH-1:0]    buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0]    buf1_q, buf1_d;

   logic [DATA_WIDTH-1:0]    ram_rdata;
   logic                     pop;
   logic                     push;
   logic                     issue;
   logic [2:0]               occupancy;
   logic                     drained;

   sync_ram_sdp #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_ram (
      .clk          (clk),
      .write_enable (write_enable),
      .address_in_w (address_in_w),
      .data_in      (data_in),
      .address_in_r (raddr_q),
      .data_out     (ram_rdata)
   );

   assign pop     = data_valid && data_ready;
   assign push    = inflight_q;
   assign drained = (count_q == 2'd0) && !inflight_q;

   // Slots committed after this edge: buffered words plus the word in flight
   // minus the one leaving now. Issuing only below depth means the push one
   // cycle later always has room.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == ST_RUN) && (remaining_q != '0) &&
                      (occupancy < 3'(BUF_DEPTH));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         raddr_q     <= '0;
         remaining_q <= '0;
         inflight_q  <= 1'b0;
         count_q     <= 2'd0;
         buf0_q      <= '0;
         buf1_q      <= '0;
      end else begin
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         remaining_q <= remaining_d;
         inflight_q  <= inflight_d;
         count_q     <= count_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      raddr_d     = raddr_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               raddr_d     = start_address;
               remaining_d = length;
               state_d     = (length != '0) ? ST_RUN : ST_DRAIN;
            end
         end
         ST_RUN: begin
            if (issue) begin
               raddr_d     = raddr_q + 1'b1;   // wraps past the top address
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == (ADDRESS_WIDTH+1)'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drained) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------ output buffer FIFO
   always_comb begin
      inflight_d = issue;
      count_d    = count_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      case ({push, pop})
         2'b11: begin
            if (count_q == 2'd1) begin
               buf0_d = ram_rdata;
            end else begin
               buf0_d = buf1_q;
               buf1_d = ram_rdata;
            end
         end
         2'b10: begin
            if (count_q == 2'd0) begin
               buf0_d = ram_rdata;
            end else begin
               buf1_d = ram_rdata;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            buf0_d  = buf1_q;
            count_d = count_q - 2'd1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DRAIN) && drained;
      data_valid = (count_q != 2'd0);
      data_out   = buf0_q;
   end

endmodule
`default_nettype wire
